// File: rtl/dma_zx_seq_if.sv
// Bus bundle for dma_zx_seq: Z80 register port, bus request/acknowledge,
// memory write port and the ZX-side byte source.
interface dma_zx_seq_if;
  // Handshakes: a register write happens on the clock where dma_wrstb and
  // dma_select are both 1. A source byte is taken on the clock where
  // src_req=1 and src_rdy=1. A memory write happens on each clock with mem_we_n=0.
  logic [7:0]  dma_din;
  logic [7:0]  dma_dout;
  logic        dma_select;
  logic        dma_wrstb;
  logic [1:0]  dma_regsel;
  logic        busrq_n;
  logic        busak_n;
  logic [20:0] mem_a;
  logic [7:0]  mem_do;
  logic        mem_we_n;
  logic        src_req;
  logic        src_rdy;
  logic [7:0]  src_data;

  modport master (
    output dma_din, dma_select, dma_wrstb, dma_regsel, busak_n, src_rdy, src_data,
    input  dma_dout, busrq_n, mem_a, mem_do, mem_we_n, src_req
  );

  modport slave (
    input  dma_din, dma_select, dma_wrstb, dma_regsel, busak_n, src_rdy, src_data,
    output dma_dout, busrq_n, mem_a, mem_do, mem_we_n, src_req
  );
endinterface

// File: rtl/dma_zx_seq.sv
// ZX-source to memory DMA sequencer: it requests the Z80 bus and copies count+1 bytes to a 21-bit address.
// Optional macro DMA_IRQ_EN adds the dma_int transfer-done interrupt output.
module dma_zx_seq (
  input  logic       cpu_clock,
  input  logic       rst_n,
  dma_zx_seq_if.slave bus,
`ifdef DMA_IRQ_EN
  output logic       dma_int,
`endif
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSREQ  = 3'd1,
    S_FETCH   = 3'd2,
    S_WRITE   = 3'd3,
    S_NEXT    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [20:0] addr_q, addr_d;
  logic [6:0]  count_q, count_d;
  logic        abort_q, abort_d;
  logic [7:0]  mem_do_q, mem_do_d;
  logic        busak_s1_q, busak_s2_q;
  logic        busrq_n_c, src_req_c, mem_we_n_c;

  logic wr_en, cst_wr, busy;
  assign wr_en  = bus.dma_wrstb & bus.dma_select;
  assign cst_wr = wr_en && (bus.dma_regsel == 2'd3);
  assign busy   = (state_q != S_IDLE);

  // busak_n comes straight off the Z80 pin, so it is synchronized before use.
  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      busak_s1_q <= 1'b1;
      busak_s2_q <= 1'b1;
    end else begin
      busak_s1_q <= bus.busak_n;
      busak_s2_q <= busak_s1_q;
    end
  end

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      abort_q  <= 1'b0;
      mem_do_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      abort_q  <= abort_d;
      mem_do_q <= mem_do_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    abort_d    = abort_q;
    mem_do_d   = mem_do_q;
    busrq_n_c  = 1'b1;
    src_req_c  = 1'b0;
    mem_we_n_c = 1'b1;

    if (wr_en && !busy) begin
      case (bus.dma_regsel)
        2'd0:    addr_d[20:16] = bus.dma_din[4:0];
        2'd1:    addr_d[15:8]  = bus.dma_din;
        2'd2:    addr_d[7:0]   = bus.dma_din;
        default: ;
      endcase
    end
    if (cst_wr && busy && !bus.dma_din[7]) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cst_wr && bus.dma_din[7]) begin
          count_d = bus.dma_din[6:0];
          state_d = S_BUSREQ;
        end
      end
      S_BUSREQ: begin
        busrq_n_c = 1'b0;
        if (abort_q)          state_d = S_RELEASE;
        else if (!busak_s2_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        busrq_n_c = 1'b0;
        src_req_c = 1'b1;
        // A byte arriving together with abort is still written.
        if (bus.src_rdy) begin
          mem_do_d = bus.src_data;
          state_d  = S_WRITE;
        end else if (abort_q) begin
          state_d = S_RELEASE;
        end
      end
      S_WRITE: begin
        busrq_n_c  = 1'b0;
        mem_we_n_c = 1'b0;
        state_d    = S_NEXT;
      end
      S_NEXT: begin
        busrq_n_c = 1'b0;
        addr_d    = addr_q + 21'd1;
        if (count_q == 7'd0 || abort_q) begin
          state_d = S_RELEASE;
        end else begin
          count_d = count_q - 7'd1;
          state_d = S_FETCH;
        end
      end
      S_RELEASE: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign bus.busrq_n  = busrq_n_c;
  assign bus.src_req  = src_req_c;
  assign bus.mem_we_n = mem_we_n_c;
  assign bus.mem_a    = addr_q;
  assign bus.mem_do   = mem_do_q;
  assign dbg_state_o  = state_q;

  always_comb begin
    case (bus.dma_regsel)
      2'd0:    bus.dma_dout = {3'b000, addr_q[20:16]};
      2'd1:    bus.dma_dout = addr_q[15:8];
      2'd2:    bus.dma_dout = addr_q[7:0];
      default: bus.dma_dout = {busy, count_q};
    endcase
  end

`ifdef DMA_IRQ_EN
  logic dma_int_q;
  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n)                                            dma_int_q <= 1'b0;
    else if (state_d == S_RELEASE && state_q != S_RELEASE) dma_int_q <= 1'b1;
    else if (cst_wr)                                       dma_int_q <= 1'b0;
  end
  assign dma_int = dma_int_q;
`endif

endmodule

// File: tb/tb_dma_zx_seq.sv
// Directed bench for dma_zx_seq: Z80 bus-grant model, byte source model and a
// memory-write scoreboard. Build with DMA_IRQ_EN defined to cover dma_int.
module tb_dma_zx_seq;

  logic       cpu_clock = 1'b0;
  logic       rst_n     = 1'b0;
  logic [2:0] dbg_state;
`ifdef DMA_IRQ_EN
  logic       dma_int;
`endif

  dma_zx_seq_if dif ();

  dma_zx_seq dut (
    .cpu_clock   (cpu_clock),
    .rst_n       (rst_n),
    .bus         (dif),
`ifdef DMA_IRQ_EN
    .dma_int     (dma_int),
`endif
    .dbg_state_o (dbg_state)
  );

  always #5 cpu_clock = ~cpu_clock;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [28:0] exp_q[$];
  logic [7:0]  src_q[$];
  logic        grant_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Z80 side: grant the bus 4 clocks after busrq_n falls, drop the grant when it rises.
  initial begin
    int gcnt = 0;
    dif.busak_n = 1'b1;
    forever begin
      @(negedge cpu_clock);
      if (dif.busrq_n !== 1'b0) begin
        dif.busak_n = 1'b1;
        gcnt = 0;
      end else if (grant_en) begin
        gcnt++;
        if (gcnt >= 4) dif.busak_n = 1'b0;
      end
    end
  end

  // Byte source: answers src_req after one clock of latency with a one-clock src_rdy pulse.
  initial begin
    int lat = 0;
    dif.src_rdy  = 1'b0;
    dif.src_data = 8'h00;
    forever begin
      @(negedge cpu_clock);
      dif.src_rdy = 1'b0;
      if (dif.src_req === 1'b1 && src_q.size() > 0) begin
        if (lat >= 1) begin
          dif.src_rdy  = 1'b1;
          dif.src_data = src_q.pop_front();
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Memory scoreboard: every write strobe must match the next expected {addr, data}.
  initial begin
    forever begin
      @(negedge cpu_clock);
      if (dif.mem_we_n === 1'b0) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("unexpected_write", 32'(exp_q.size()), 32'd1);
        else check("mem_write", {3'b000, dif.mem_a, dif.mem_do}, {3'b000, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    @(negedge cpu_clock);
    dif.dma_regsel = sel;
    dif.dma_din    = d;
    dif.dma_select = 1'b1;
    dif.dma_wrstb  = 1'b1;
    @(negedge cpu_clock);
    dif.dma_select = 1'b0;
    dif.dma_wrstb  = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    @(negedge cpu_clock);
    dif.dma_regsel = sel;
    #1;
    check(tag, {24'h0, dif.dma_dout}, {24'h0, exp});
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max);
    int n = 0;
    while (dbg_state !== s && n < max) begin
      @(negedge cpu_clock);
      n++;
    end
    check(tag, {29'h0, dbg_state}, {29'h0, s});
  endtask

  task automatic wait_writes(input string tag, input int target, input int max);
    int n = 0;
    while (wr_cnt < target && n < max) begin
      @(negedge cpu_clock);
      n++;
    end
    check(tag, wr_cnt, target);
  endtask

  task automatic set_addr(input logic [7:0] h, input logic [7:0] m, input logic [7:0] l);
    wr(2'd0, h);
    wr(2'd1, m);
    wr(2'd2, l);
  endtask

  initial begin
    int base;
    dif.dma_din    = 8'h00;
    dif.dma_select = 1'b0;
    dif.dma_wrstb  = 1'b0;
    dif.dma_regsel = 2'd0;

    // Reset values
    repeat (3) @(negedge cpu_clock);
    check("rst_busrq_n",  {31'h0, dif.busrq_n},  32'd1);
    check("rst_mem_we_n", {31'h0, dif.mem_we_n}, 32'd1);
    check("rst_src_req",  {31'h0, dif.src_req},  32'd0);
    check("rst_mem_do",   {24'h0, dif.mem_do},   32'd0);
`ifdef DMA_IRQ_EN
    check("rst_dma_int",  {31'h0, dma_int},      32'd0);
`endif
    rst_n = 1'b1;
    chk_reg("rst_had", 2'd0, 8'h00);
    chk_reg("rst_mad", 2'd1, 8'h00);
    chk_reg("rst_lad", 2'd2, 8'h00);
    chk_reg("rst_cst", 2'd3, 8'h00);

    // Three-byte transfer at 0x051234
    set_addr(8'h05, 8'h12, 8'h34);
    chk_reg("t1_had", 2'd0, 8'h05);
    chk_reg("t1_mad", 2'd1, 8'h12);
    chk_reg("t1_lad", 2'd2, 8'h34);
    exp_q.push_back({21'h051234, 8'hA1});
    exp_q.push_back({21'h051235, 8'hA2});
    exp_q.push_back({21'h051236, 8'hA3});
    src_q = '{8'hA1, 8'hA2, 8'hA3};
    base = wr_cnt;
    wr(2'd3, 8'h82);
    chk_reg("t1_cst_busy", 2'd3, 8'h82);
    wait_state("t1_done", 3'd0, 200);
    check("t1_writes", wr_cnt - base, 3);
    check("t1_exp_left", exp_q.size(), 0);
    check("t1_busrq_n", {31'h0, dif.busrq_n}, 32'd1);
    chk_reg("t1_cst", 2'd3, 8'h00);
    chk_reg("t1_lad_after", 2'd2, 8'h37);
`ifdef DMA_IRQ_EN
    check("t1_dma_int_set", {31'h0, dma_int}, 32'd1);
    wr(2'd3, 8'h00);
    check("t1_dma_int_clr", {31'h0, dma_int}, 32'd0);
    chk_reg("t1_cst_idle0", 2'd3, 8'h00);
`endif

    // Address wrap 0x1FFFFF -> 0x000000
    set_addr(8'h1F, 8'hFF, 8'hFF);
    exp_q.push_back({21'h1FFFFF, 8'hB0});
    exp_q.push_back({21'h000000, 8'hB1});
    src_q = '{8'hB0, 8'hB1};
    base = wr_cnt;
    wr(2'd3, 8'h81);
    wait_state("t2_done", 3'd0, 200);
    check("t2_writes", wr_cnt - base, 2);
    chk_reg("t2_had", 2'd0, 8'h00);
    chk_reg("t2_mad", 2'd1, 8'h00);
    chk_reg("t2_lad", 2'd2, 8'h01);
    chk_reg("t2_cst", 2'd3, 8'h00);

    // Abort after two bytes of a 128-byte transfer; address writes while busy are ignored
    set_addr(8'h00, 8'h01, 8'h00);
    exp_q.push_back({21'h000100, 8'hC1});
    exp_q.push_back({21'h000101, 8'hC2});
    src_q = '{8'hC1, 8'hC2};
    base = wr_cnt;
    wr(2'd3, 8'hFF);
    wait_writes("t3_two_bytes", base + 2, 200);
    wait_state("t3_fetch_wait", 3'd2, 20);
    wr(2'd2, 8'h55);
    wr(2'd3, 8'h81);
    wr(2'd3, 8'h00);
    wait_state("t3_done", 3'd0, 20);
    check("t3_writes", wr_cnt - base, 2);
    check("t3_busrq_n", {31'h0, dif.busrq_n}, 32'd1);
    chk_reg("t3_cst", 2'd3, 8'h7D);
    chk_reg("t3_lad", 2'd2, 8'h02);
    chk_reg("t3_mad", 2'd1, 8'h01);

    // Abort while the bus is never granted
    grant_en = 1'b0;
    base = wr_cnt;
    wr(2'd3, 8'h80);
    check("t4_busrq_low", {31'h0, dif.busrq_n}, 32'd0);
    wr(2'd3, 8'h00);
    begin
      int n = 0;
      while (dif.busrq_n !== 1'b1 && n < 2) begin
        @(negedge cpu_clock);
        n++;
      end
    end
    check("t4_busrq_release", {31'h0, dif.busrq_n}, 32'd1);
    wait_state("t4_done", 3'd0, 10);
    check("t4_writes", wr_cnt - base, 0);
    chk_reg("t4_cst", 2'd3, 8'h00);
    grant_en = 1'b1;

    // Reset asserted while in WRITE
    set_addr(8'h00, 8'h02, 8'h00);
    exp_q.push_back({21'h000200, 8'hD1});
    src_q = '{8'hD1, 8'hD2};
    wr(2'd3, 8'h81);
    wait_state("t5_in_write", 3'd3, 200);
    #2 rst_n = 1'b0;
    #1;
    check("t5_mem_we_n", {31'h0, dif.mem_we_n}, 32'd1);
    check("t5_busrq_n",  {31'h0, dif.busrq_n},  32'd1);
    check("t5_state",    {29'h0, dbg_state},    32'd0);
    check("t5_mem_do",   {24'h0, dif.mem_do},   32'd0);
    base = wr_cnt;
    repeat (3) @(negedge cpu_clock);
    src_q.delete();
    rst_n = 1'b1;
    chk_reg("t5_had", 2'd0, 8'h00);
    chk_reg("t5_mad", 2'd1, 8'h00);
    chk_reg("t5_lad", 2'd2, 8'h00);
    chk_reg("t5_cst", 2'd3, 8'h00);
    repeat (10) @(negedge cpu_clock);
    check("t5_no_more_writes", wr_cnt - base, 0);
    check("t5_exp_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_zx_seq.md
DMA_ZX_SEQ -- requirements
Module: dma_zx_seq

Interface
REQ-001 cpu_clock  in  1  Z80 clock; all logic on the rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 dma_din  in  8  register write data from the Z80 bus.
REQ-004 dma_dout  out  8  register read data selected by dma_regsel.
REQ-005 dma_select  in  1  this module is the selected DMA module.
REQ-006 dma_wrstb  in  1  one-clock register write strobe.
REQ-007 dma_regsel  in  2  register address: 0=HAD, 1=MAD, 2=LAD, 3=CST.
REQ-008 busrq_n  out  1  Z80 bus request, active-low.
REQ-009 busak_n  in  1  Z80 bus acknowledge, active-low, asynchronous.
REQ-010 mem_a  out  21  memory write address.
REQ-011 mem_do  out  8  memory write data.
REQ-012 mem_we_n  out  1  memory write strobe, active-low.
REQ-013 src_req  out  1  byte request to the ZX-side source.
REQ-014 src_rdy  in  1  one-clock pulse; src_data is valid in that cycle.
REQ-015 src_data  in  8  source byte.
REQ-016 dma_int  out  1  transfer-done interrupt; present only under DMA_IRQ_EN.

Function
REQ-017 Registers are written only when dma_wrstb=1 and dma_select=1.
- HAD[4:0] holds address bits 20:16; MAD holds 15:8; LAD holds 7:0.
- HAD, MAD and LAD writes are ignored while busy=1.
REQ-018 CST write, idle: din[7]=1 loads count=din[6:0] (transfer length count+1, range 1..128) and enters BUSREQ; din[7]=0 does nothing.
REQ-019 CST write while busy with din[7]=0 sets abort; din[7]=1 while busy is ignored.
REQ-020 Reads: HAD returns {3'b0, addr[20:16]}; MAD/LAD return the live address bytes; CST returns {busy, count[6:0]}.
REQ-021 busak_n passes through a two-flop synchronizer before use.
REQ-022 FSM states are IDLE, BUSREQ, FETCH, WRITE, NEXT, RELEASE.
REQ-023 IDLE: busrq_n=1, src_req=0, mem_we_n=1, busy=0.
REQ-024 BUSREQ: busrq_n=0; go to FETCH when synchronized busak=0; go to RELEASE if abort is set.
REQ-025 FETCH: src_req=1 and busrq_n=0; on src_rdy latch src_data into mem_do and go to WRITE; go to RELEASE if abort is set and src_rdy=0.
REQ-026 WRITE: mem_we_n=0 for exactly one clock with mem_a and mem_do stable, then go to NEXT.
REQ-027 NEXT: address increments with wrap 0x1FFFFF->0x000000.
- count=0 or abort set: go to RELEASE.
- Otherwise decrement count and go to FETCH.
REQ-028 A byte latched before abort is always written; abort never truncates a WRITE.
REQ-029 RELEASE: busrq_n=1 for one clock, clear abort, go to IDLE.
- CST then reads the remaining count, which is 0 after a full transfer.
REQ-030 A CST write in the same cycle as a NEXT-to-RELEASE transition is treated as an idle write in the following cycle only if it is re-issued; a simultaneous write is dropped.
REQ-031 src_rdy outside FETCH is ignored.
REQ-032 Throughput is at most one byte per 3 clocks after bus grant, plus source latency.

Reset
REQ-033 Reset values: HAD/MAD/LAD=0, count=0, abort=0, state IDLE, busrq_n=1, mem_we_n=1, src_req=0, mem_do=0, dma_int=0.
REQ-034 Reset mid-transfer releases the bus immediately, asynchronously; no further write occurs.

Configuration
REQ-035 Macro DMA_IRQ_EN defined:
- dma_int is set to 1 on entry to RELEASE.
- dma_int is cleared by any selected CST write.
- Set takes priority over clear in the same cycle.
REQ-036 Macro DMA_IRQ_EN undefined: the dma_int port and its logic are absent.

Verification
REQ-037 HAD=0x05, MAD=0x12, LAD=0x34, CST=0x82, busak granted after 4 clocks, three src_rdy pulses with 0xA1/0xA2/0xA3 -> writes at 0x051234..0x051236, then busrq_n=1 and CST reads 0x00.
REQ-038 LAD=MAD=0xFF, HAD=0x1F, CST=0x81 -> bytes written at 0x1FFFFF then 0x000000.
REQ-039 CST=0xFF, then after 2 bytes write CST=0x00 -> at most 3 bytes written, bus released, CST busy=0, count=0x7D or 0x7C.
REQ-040 busak_n held high, CST=0x80, then CST=0x00 -> no mem_we_n pulse, busrq_n returns to 1 within 2 clocks.
REQ-041 rst_n pulsed low in the WRITE state -> mem_we_n=1 and busrq_n=1 immediately; all registers read 0.
REQ-042 With DMA_IRQ_EN: completion sets dma_int=1; a CST write clears it; without DMA_IRQ_EN the bench compiles with no dma_int port.
